// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave oversampled in the clk domain.
// Framed traffic (cs low, frame low) becomes 32-bit receive words. Unframed
// traffic (cs low, frame high) becomes 8-bit OOB bytes. Transmit words come
// from a one-entry valid/ready holding register and are shifted out LSB first.
// Optional feature macro: SPI_SLAVE_OOB_EN enables the OOB byte mode. Without
// it, cs low with frame high behaves as IDLE.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | cs high (or unframed traffic when OOB is compiled out)
// ST_OOB  | cs low, frame high: 8-bit out-of-band bytes
// ST_WORD | cs low, frame low: 32-bit framed words
module spi_slave_if #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    input  logic        spi_cs,
    input  logic        spi_frame,
    output logic        spi_miso,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        rx_oob,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        tx_underrun,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OOB  = 2'd1,
        ST_WORD = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] frame_sync;

    logic sclk_l, sclk_p, mosi_l, cs_l, frame_l;
    logic rise, fall;

    state_t      state, state_next;
    logic [4:0]  count;
    logic [5:0]  count_inc;
    logic [5:0]  unit_len;
    logic [31:0] rx_shift, rx_next;
    logic [31:0] tx_shift;
    logic        pend_load;
    logic        hold_full;
    logic [31:0] hold_data;

    logic load, clear, sample, complete, shift_out, ferr;

    // Synchronize the SPI pins; cs and frame idle high so they reset high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync  <= '0;
            mosi_sync  <= '0;
            cs_sync    <= '1;
            frame_sync <= '1;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            frame_sync <= {frame_sync[SYNC_STAGES-2:0], spi_frame};
        end
    end

    // Level stage plus previous spi_clk so all decisions act SYNC_STAGES+2 after a pin change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_l  <= 1'b0;
            sclk_p  <= 1'b0;
            mosi_l  <= 1'b0;
            cs_l    <= 1'b1;
            frame_l <= 1'b1;
        end else begin
            sclk_l  <= sclk_sync[SYNC_STAGES-1];
            sclk_p  <= sclk_l;
            mosi_l  <= mosi_sync[SYNC_STAGES-1];
            cs_l    <= cs_sync[SYNC_STAGES-1];
            frame_l <= frame_sync[SYNC_STAGES-1];
        end
    end

    assign rise    = sclk_l & ~sclk_p;
    assign fall    = ~sclk_l & sclk_p;
    assign rx_next = {mosi_l, rx_shift[31:1]};

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next state and per-cycle datapath controls
    always_comb begin
        state_next = state;
        load       = 1'b0;
        clear      = 1'b0;
        sample     = 1'b0;
        complete   = 1'b0;
        shift_out  = 1'b0;
        ferr       = 1'b0;
        unit_len   = (state == ST_OOB) ? 6'd8 : 6'd32;
        count_inc  = {1'b0, count} + 6'd1;

        if (cs_l) begin
            state_next = ST_IDLE;
        end else if (!frame_l) begin
            state_next = ST_WORD;
        end else begin
`ifdef SPI_SLAVE_OOB_EN
            state_next = ST_OOB;
`else
            state_next = ST_IDLE;
`endif
        end

        if (state_next != state) begin
            // Any mode change discards the partial unit; only a frame change
            // (cs still low) with bits already shifted is an error.
            clear = 1'b1;
            if (state_next != ST_IDLE) load = 1'b1;
            if (!cs_l && state != ST_IDLE && count != 5'd0) ferr = 1'b1;
        end else if (state != ST_IDLE) begin
            sample   = rise;
            complete = rise && (count_inc == unit_len);
            if (fall) begin
                if (pend_load) load      = 1'b1;
                else           shift_out = 1'b1;
            end
        end
    end

    // Receive/transmit shifters, bit counter and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            pend_load   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid    <= complete;
            tx_underrun <= load & ~hold_full;
            frame_err   <= ferr;

            if (clear) begin
                count    <= '0;
                rx_shift <= '0;
            end else if (sample) begin
                rx_shift <= rx_next;
                count    <= complete ? 5'd0 : count_inc[4:0];
            end

            if (clear)         pend_load <= 1'b0;
            else if (complete) pend_load <= 1'b1;
            else if (load)     pend_load <= 1'b0;

            if (complete) begin
                rx_data <= (state == ST_OOB) ? {24'h0, rx_next[31:24]} : rx_next;
            end

            if (load)           tx_shift <= hold_full ? hold_data : 32'h0;
            else if (clear)     tx_shift <= '0;
            else if (shift_out) tx_shift <= {1'b0, tx_shift[31:1]};
        end
    end

    // Holding register; a load in the same cycle as an accept sees it empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (tx_valid && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end else if (load && hold_full) begin
            hold_full <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_OOB_EN
    // Tag each received unit with the mode it arrived in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rx_oob <= 1'b0;
        else if (complete) rx_oob <= (state == ST_OOB);
    end
`else
    assign rx_oob = 1'b0;
`endif

    assign tx_ready = ~hold_full;
    assign spi_miso = tx_shift[0];

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

Clock-domain SPI slave that consumes the bench SPI master's pins (spi_clk, spi_mosi, spi_cs, spi_frame) and drives spi_miso. It oversamples all SPI inputs in the system clock domain. It converts framed traffic into 32-bit receive words, and unframed traffic into 8-bit out-of-band (OOB) bytes. Transmit data is taken from a valid/ready holding register and shifted out LSB first.

## Interface
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on spi_clk/spi_mosi/spi_cs/spi_frame (min 2)
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- spi_clk  in  1  SPI clock, idle low; sample on rising edge
- spi_mosi  in  1  serial data from master, LSB first
- spi_cs  in  1  active-low chip select
- spi_frame  in  1  active-low word-frame qualifier; high with cs low = OOB byte mode
- spi_miso  out  1  serial data to master, LSB first
- rx_data  out  32  received word; OOB byte in [7:0], [31:8]=0
- rx_valid  out  1  one-cycle pulse, rx_data valid
- rx_oob  out  1  qualifies rx_valid: 1=OOB byte, 0=framed word
- tx_data  in  32  next transmit word; OOB uses [7:0]
- tx_valid  in  1  tx_data offered
- tx_ready  out  1  holding register empty; transfer when tx_valid&&tx_ready
- tx_underrun  out  1  one-cycle pulse: unit load found holding register empty
- frame_err  out  1  one-cycle pulse: spi_frame changed with partial unit shifted

## Operation
- Inputs pass through SYNC_STAGES flops; edges detected on the synchronized spi_clk (rise = sample, fall = shift-out).
- States:
  - IDLE: cs high.
  - OOB: cs low, frame high.
  - WORD: cs low, frame low.
- Transitions are evaluated on synchronized levels. A cs rise from any state returns to IDLE and clears the bit counter and shift registers, with no rx_valid.
- Bit counter is 5 bits. Unit length is 8 in OOB and 32 in WORD.
- Each spi_clk rise: rx_shift = {mosi, rx_shift[31:1]} (OOB uses the [31:24] window shifted down on completion), then count++.
- Completion: count reaches unit length on a rise. rx_data is loaded (OOB: the byte right-aligned), rx_valid pulses, and rx_oob = (state==OOB). Count wraps to 0.
- There is no receive backpressure. The consumer must accept rx_valid in the pulse cycle.
- Unit load of the transmit shifter happens on:
  - entry to OOB or WORD;
  - the spi_clk fall after each completion.
- At unit load:
  - If the holding register is full, its data moves to tx_shift and the register empties (tx_ready rises the next cycle).
  - If it is empty, tx_shift=0 and tx_underrun pulses.
- spi_miso = tx_shift[0]. tx_shift shifts right on each spi_clk fall that is not a unit load.
- A frame change with count≠0 pulses frame_err. The partial unit is discarded, count clears, and a new unit load occurs in the new state.
- Holding register accepts tx_valid&&tx_ready in any state. Its content persists across cs deassertion.

## Timing
- Reset values:
  - spi_miso=0, rx_data=0, rx_valid=0, rx_oob=0.
  - tx_ready=1, tx_underrun=0, frame_err=0.
  - state=IDLE, count=0, holding register empty.
- rx_valid asserts SYNC_STAGES+2 clk cycles after the spi_clk rise carrying the last bit.
- spi_miso updates SYNC_STAGES+2 cycles after a spi_clk fall, cs fall, or frame fall.
- Requirement on the master: spi_clk high time, spi_clk low time, and cs/frame-fall-to-first-rise are each ≥ SYNC_STAGES+4 clk cycles. For SYNC_STAGES=2 and a 20 ns half-period, clk ≥ 300 MHz.
- Simultaneous tx_valid&&tx_ready and unit load in the same cycle: the unit load sees the register as empty (underrun). The new data stays held for the next unit.
- Reset asserted mid-unit: all state clears immediately and asynchronously. No rx_valid for the partial unit.

## Configuration
- SPI_SLAVE_OOB_EN defined: OOB state, OOB reception, and OOB transmit are present as described.
- SPI_SLAVE_OOB_EN undefined:
  - cs low with frame high is treated as IDLE: bits are ignored, count is held at 0, and spi_miso=0.
  - rx_oob is tied 0.
  - No unit loads occur outside WORD.

## Test plan
- Framed word: preload tx 32'hCAFEF00D; master frames and sends 32'h12345678 -> rx_valid once, rx_data=32'h12345678, rx_oob=0; master reads 32'hCAFEF00D.
- OOB bytes: preload tx 8'hA5, then 8'h3C after the first load; master sends 8'h81, 8'h7E -> two rx_valid pulses with rx_oob=1 and rx_data=32'h00000081 then 32'h0000007E; master reads A5 then 3C.
- Back-to-back: four framed words 1,2,3,4 with tx kept full (10,20,30,40) -> four rx_valid pulses in order; master reads 10,20,30,40; no tx_underrun.
- Underrun: frame one word with the holding register empty -> tx_underrun pulses once; master reads 32'h00000000; rx still correct.
- Frame abort: raise frame after 12 bits, then send an OOB byte 8'h55 -> frame_err pulses, no word rx_valid, then rx_data=32'h00000055 with rx_oob=1.
- Reset mid-word: assert rst_n low after 20 bits -> all outputs at reset values, tx_ready=1; the next full word is received correctly.
